// File: rtl/tx_retry_pkg.sv
// Shared types and default timing for the half-duplex TX retry controller.
// Timing defaults are in nibble-rate clocks (4 bit times per clock).
package tx_retry_pkg;

  localparam int unsigned IFG_CYCLES_DEFAULT   = 24;
  localparam int unsigned JAM_CYCLES_DEFAULT   = 8;
  localparam int unsigned SLOT_CYCLES_DEFAULT  = 128;
  localparam int unsigned MAX_ATTEMPTS_DEFAULT = 16;

  typedef enum logic [2:0] {
    IDLE,
    DEFER,
    IFG,
    TX,
    JAM,
    BACKOFF_INIT,
    BACKOFF_WAIT
  } tx_state_e;

  // Backoff exponent handed to random_gen: collisions so far minus one, capped at 15.
  function automatic logic [3:0] retry_from_count(input logic [4:0] coll);
    logic [4:0] m;
    m = (coll == 5'd0) ? 5'd0 : coll - 5'd1;
    return (m > 5'd15) ? 4'hF : m[3:0];
  endfunction

endpackage

// File: rtl/tx_retry_ctrl.sv
// CSMA/CD transmit retry FSM: defer, inter-frame gap, collision jam, backoff handshake.
// All outputs registered (one clock after the deciding edge); no backpressure, tx_req is a level.
module tx_retry_ctrl
  import tx_retry_pkg::*;
#(
  parameter int unsigned IFG_CYCLES   = IFG_CYCLES_DEFAULT,
  parameter int unsigned JAM_CYCLES   = JAM_CYCLES_DEFAULT,
  parameter int unsigned SLOT_CYCLES  = SLOT_CYCLES_DEFAULT,
  parameter int unsigned MAX_ATTEMPTS = MAX_ATTEMPTS_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       tx_req,
  input  logic       carrier_sense,
  input  logic       collision,
  input  logic       tx_done,
  input  logic       backoff_trigger,
  output logic       tx_start,
  output logic       jam,
  output logic       backoff_init,
  output logic [3:0] retry_count,
  output logic       tx_ok,
  output logic       tx_abort,
  output logic       late_collision,
  output logic       busy
);

  localparam int unsigned CNT_W  = $clog2(IFG_CYCLES + JAM_CYCLES + 1);
  localparam int unsigned SLOT_W = $clog2(SLOT_CYCLES + 1);

  localparam logic [CNT_W-1:0]  IFG_LOAD     = CNT_W'(IFG_CYCLES - 1);
  localparam logic [CNT_W-1:0]  JAM_LOAD     = CNT_W'(JAM_CYCLES - 1);
  localparam logic [SLOT_W-1:0] SLOT_SAT     = SLOT_W'(SLOT_CYCLES);
  localparam logic [4:0]        ATTEMPTS_MAX = 5'(MAX_ATTEMPTS);

  tx_state_e         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [4:0]        coll_q, coll_d;
  logic              late_q, late_d;
  logic              first_q, first_d;
  logic [3:0]        retry_q, retry_d;

  logic tx_start_q, tx_start_d;
  logic jam_q, jam_d;
  logic binit_q, binit_d;
  logic tx_ok_q, tx_ok_d;
  logic tx_abort_q, tx_abort_d;
  logic late_coll_q, late_coll_d;
  logic busy_q, busy_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    coll_d      = coll_q;
    late_d      = late_q;
    first_d     = first_q;
    retry_d     = retry_q;
    tx_start_d  = 1'b0;
    jam_d       = 1'b0;
    binit_d     = 1'b0;
    tx_ok_d     = 1'b0;
    tx_abort_d  = 1'b0;
    late_coll_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (tx_req) begin
          state_d = DEFER;
          coll_d  = 5'd0;
          late_d  = 1'b0;
          retry_d = 4'h0;
        end
      end

      DEFER: begin
        if (!carrier_sense) begin
          state_d = IFG;
          cnt_d   = IFG_LOAD;
        end
      end

      // The shared counter runs down; zero marks the last gap clock.
      IFG: begin
        if (carrier_sense) begin
          state_d = DEFER;
        end else if (cnt_q == '0) begin
          state_d    = TX;
          tx_start_d = 1'b1;
          slot_d     = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      TX: begin
        if (slot_q != SLOT_SAT) slot_d = slot_q + SLOT_W'(1);
        if (collision) begin
          state_d = JAM;
          jam_d   = 1'b1;
          cnt_d   = JAM_LOAD;
          if (coll_q != ATTEMPTS_MAX) coll_d = coll_q + 5'd1;
          late_d  = (slot_q >= SLOT_SAT);
        end else if (tx_done) begin
          state_d = IDLE;
          tx_ok_d = 1'b1;
        end
      end

      JAM: begin
        if (cnt_q == '0) begin
          if (late_q) begin
            state_d     = IDLE;
            tx_abort_d  = 1'b1;
            late_coll_d = 1'b1;
          end else if (coll_q == ATTEMPTS_MAX) begin
            state_d    = IDLE;
            tx_abort_d = 1'b1;
          end else begin
            state_d = BACKOFF_INIT;
            binit_d = 1'b1;
            retry_d = retry_from_count(coll_q);
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
          jam_d = 1'b1;
        end
      end

      BACKOFF_INIT: begin
        state_d = BACKOFF_WAIT;
        first_d = 1'b1;
      end

      // random_gen needs a clock after init before its trigger is meaningful.
      BACKOFF_WAIT: begin
        if (first_q) begin
          first_d = 1'b0;
        end else if (backoff_trigger) begin
          state_d = DEFER;
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      slot_q      <= '0;
      coll_q      <= 5'd0;
      late_q      <= 1'b0;
      first_q     <= 1'b0;
      retry_q     <= 4'h0;
      tx_start_q  <= 1'b0;
      jam_q       <= 1'b0;
      binit_q     <= 1'b0;
      tx_ok_q     <= 1'b0;
      tx_abort_q  <= 1'b0;
      late_coll_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      coll_q      <= coll_d;
      late_q      <= late_d;
      first_q     <= first_d;
      retry_q     <= retry_d;
      tx_start_q  <= tx_start_d;
      jam_q       <= jam_d;
      binit_q     <= binit_d;
      tx_ok_q     <= tx_ok_d;
      tx_abort_q  <= tx_abort_d;
      late_coll_q <= late_coll_d;
      busy_q      <= busy_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign jam            = jam_q;
  assign backoff_init   = binit_q;
  assign retry_count    = retry_q;
  assign tx_ok          = tx_ok_q;
  assign tx_abort       = tx_abort_q;
  assign late_collision = late_coll_q;
  assign busy           = busy_q;

endmodule

// File: tb/tb_tx_retry_ctrl.sv
// Directed bench for tx_retry_ctrl with hand-computed edge counts.
// Inputs change 1 ns after a rising edge; outputs are sampled at that same point.
module tb_tx_retry_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       tx_req = 1'b0;
  logic       carrier_sense = 1'b0;
  logic       collision = 1'b0;
  logic       tx_done = 1'b0;
  logic       backoff_trigger = 1'b0;
  logic       tx_start, jam, backoff_init, tx_ok, tx_abort, late_collision, busy;
  logic [3:0] retry_count;

  int vectors = 0;
  int miscompares = 0;
  int ok_cnt = 0;
  int abort_cnt = 0;
  int binit_cnt = 0;
  int both_cnt = 0;

  always #5 clock = ~clock;

  tx_retry_ctrl dut (
    .clock          (clock),
    .reset          (reset),
    .tx_req         (tx_req),
    .carrier_sense  (carrier_sense),
    .collision      (collision),
    .tx_done        (tx_done),
    .backoff_trigger(backoff_trigger),
    .tx_start       (tx_start),
    .jam            (jam),
    .backoff_init   (backoff_init),
    .retry_count    (retry_count),
    .tx_ok          (tx_ok),
    .tx_abort       (tx_abort),
    .late_collision (late_collision),
    .busy           (busy)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({tx_start, jam, backoff_init, tx_ok, tx_abort, late_collision, busy, retry_count});
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
    if (tx_ok) ok_cnt++;
    if (tx_abort) abort_cnt++;
    if (backoff_init) binit_cnt++;
    if (tx_ok && tx_abort) both_cnt++;
  endtask

  task automatic wait_start(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      step();
      n++;
      if (tx_start) break;
    end
  endtask

  // n = number of edges from the tx_req sampling edge (E0 counts as 1) to tx_start.
  task automatic start_frame(output int n);
    int m;
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    wait_start(200, m);
    n = m + 1;
  endtask

  // Called right after the tx_start edge; collision is sampled while the slot counter equals slot.
  task automatic collide_at(input int slot, output int jam_len);
    repeat (slot) step();
    collision = 1'b1;
    step();
    collision = 1'b0;
    jam_len = 0;
    while (jam && jam_len < 64) begin
      jam_len++;
      step();
    end
  endtask

  task automatic trigger_backoff();
    step();
    step();
    backoff_trigger = 1'b1;
    step();
    backoff_trigger = 1'b0;
  endtask

  task automatic finish_frame();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int jl;
    int starts;

    repeat (3) step();
    check_vec("reset_outs", all_outs(), 0);
    reset = 1'b0;
    step();
    check_vec("idle_outs", all_outs(), 0);

    // Idle medium: tx_start at E25, tx_ok at E75.
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    check_vec("t1_busy", 32'(busy), 1);
    wait_start(200, n);
    check_vec("t1_start_edge", n, 25);
    step();
    check_vec("t1_start_pulse", 32'(tx_start), 0);
    repeat (48) step();
    tx_done = 1'b1;
    step();
    tx_done = 1'b0;
    check_vec("t1_ok_abort_busy", 32'({tx_ok, tx_abort, busy}), 'h4);
    step();
    check_vec("t1_ok_pulse", 32'(tx_ok), 0);

    // Carrier during IFG sends the FSM back to DEFER; full gap afterwards.
    tx_req = 1'b1;
    step();
    tx_req = 1'b0;
    repeat (9) step();
    carrier_sense = 1'b1;
    repeat (10) step();
    carrier_sense = 1'b0;
    wait_start(200, n);
    check_vec("t2_ifg_restart", n, 25);
    finish_frame();
    check_vec("t2_ok", 32'(tx_ok), 1);

    // Early collision, first-cycle trigger ignored, real trigger ~300 cycles later.
    start_frame(n);
    check_vec("t3_start", n, 26);
    collide_at(20, jl);
    check_vec("t3_jam_len", jl, 8);
    check_vec("t3_binit_retry", 32'({backoff_init, tx_abort, retry_count}), 'h20);
    step();
    check_vec("t3_binit_pulse", 32'(backoff_init), 0);
    backoff_trigger = 1'b1;
    step();
    backoff_trigger = 1'b0;
    starts = 0;
    repeat (297) begin
      step();
      if (tx_start) starts++;
    end
    check_vec("t3_first_trig_ignored", starts, 0);
    backoff_trigger = 1'b1;
    step();
    backoff_trigger = 1'b0;
    wait_start(200, n);
    check_vec("t3_restart", n, 25);
    finish_frame();
    check_vec("t3_ok", 32'(tx_ok), 1);

    // Sixteen early collisions: retry 0..14 then excessive-collision abort.
    start_frame(n);
    for (int a = 0; a < 16; a++) begin
      collide_at(5, jl);
      if (a < 15) begin
        check_vec($sformatf("t4_retry%0d", a), 32'({backoff_init, retry_count}), 32'(16 + a));
        trigger_backoff();
        wait_start(200, n);
      end else begin
        check_vec("t4_jam_len", jl, 8);
        check_vec("t4_abort", 32'({backoff_init, tx_abort, late_collision, busy}), 'h4);
      end
    end

    // Slot boundary: 127 is in-window, 128 and 130 are late.
    start_frame(n);
    check_vec("t5_retry_cleared", 32'(retry_count), 0);
    collide_at(127, jl);
    check_vec("t5_slot127", 32'({backoff_init, tx_abort, late_collision}), 'h4);
    trigger_backoff();
    wait_start(200, n);
    finish_frame();
    check_vec("t5_slot127_ok", 32'(tx_ok), 1);

    start_frame(n);
    collide_at(128, jl);
    check_vec("t5_slot128_jam", jl, 8);
    check_vec("t5_slot128", 32'({backoff_init, tx_abort, late_collision, busy}), 'h6);

    start_frame(n);
    collide_at(130, jl);
    check_vec("t5_slot130_jam", jl, 8);
    check_vec("t5_slot130", 32'({backoff_init, tx_abort, late_collision, busy}), 'h6);
    step();
    check_vec("t5_abort_pulse", 32'({tx_abort, late_collision}), 0);

    // Collision beats tx_done; then reset in BACKOFF_WAIT drops the frame.
    start_frame(n);
    repeat (10) step();
    collision = 1'b1;
    tx_done = 1'b1;
    step();
    collision = 1'b0;
    tx_done = 1'b0;
    check_vec("t6_jam_no_ok", 32'({jam, tx_ok}), 'h2);
    repeat (8) step();
    check_vec("t6_binit", 32'({backoff_init, late_collision}), 'h2);
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    check_vec("t6_async_reset", all_outs(), 0);
    step();
    reset = 1'b0;
    step();
    check_vec("t6_idle_after_reset", all_outs(), 0);

    check_vec("frames_ok", ok_cnt, 4);
    check_vec("frames_abort", abort_cnt, 3);
    check_vec("binit_total", binit_cnt, 18);
    check_vec("ok_abort_overlap", both_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
